// File: rtl/basic_io_if.sv
// Nexys Video basic I/O bundle: raw buttons/switches in, LEDs and conditioned levels out.
interface basic_io_if;
  logic [5:0] i_buttons;
  logic [7:0] i_switches;
  logic [7:0] o_leds;
  logic [1:0] o_mode;
  logic [5:0] o_btn_db;
  logic [7:0] o_sw_db;
  logic [5:0] o_btn_press;

  modport master (
    output i_buttons, i_switches,
    input  o_leds, o_mode, o_btn_db, o_sw_db, o_btn_press
  );

  modport slave (
    input  i_buttons, i_switches,
    output o_leds, o_mode, o_btn_db, o_sw_db, o_btn_press
  );
endinterface

// File: rtl/basic_io_ctrl.sv
// Basic I/O front end: synchronize and debounce buttons/switches, detect presses, drive LEDs.
//   state  | meaning
//   MIRROR | LEDs follow the debounced switches
//   COUNT  | LEDs show an 8-bit counter stepped by U/D, loaded from switches by R
//   SHIFT  | LEDs show a pattern rotated by L/R
module basic_io_ctrl #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic      i_clk,
  input  logic      i_rst,
  basic_io_if.slave io
);

  localparam int NIN = 14;
  localparam int TW  = $clog2(TICK_DIV);
  localparam int CW  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  typedef enum logic [1:0] {
    MIRROR = 2'd0,
    COUNT  = 2'd1,
    SHIFT  = 2'd2
  } mode_e;

  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [NIN-1:0] raw, sync1, sync2, stable;
  logic [CW-1:0]  db_cnt [NIN];
  logic [5:0]     btn_db, btn_d, press;
  logic [7:0]     sw_db;

  mode_e      state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] pattern_q, pattern_d;
  logic [7:0] leds_q, leds_d;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  assign raw = {io.i_switches, io.i_buttons};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Counter only advances while the input disagrees with its stable value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stable <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (tick) begin
          if (db_cnt[i] == CW'(DEBOUNCE_TICKS - 1)) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign btn_db = stable[5:0];
  assign sw_db  = stable[13:6];
  assign press  = btn_db & ~btn_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) btn_d <= '0;
    else       btn_d <= btn_db;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= MIRROR;
      count_q   <= 8'h00;
      pattern_q <= 8'h01;
      leds_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      leds_q    <= leds_d;
    end
  end

  // press bits: [0]=C [1]=U [2]=D [3]=L [4]=R [5]=AUX
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pattern_d = pattern_q;
    leds_d    = sw_db;
    if (press[5]) begin
      state_d   = MIRROR;
      count_d   = 8'h00;
      pattern_d = 8'h01;
    end else if (press[0]) begin
      case (state_q)
        MIRROR:  state_d = COUNT;
        COUNT: begin
          state_d   = SHIFT;
          pattern_d = (sw_db == 8'h00) ? 8'h01 : sw_db;
        end
        default: state_d = MIRROR;
      endcase
    end else begin
      case (state_q)
        MIRROR: ;
        COUNT: begin
          if (press[4])                  count_d = sw_db;
          else if (press[1] && !press[2]) count_d = count_q + 8'h01;
          else if (press[2] && !press[1]) count_d = count_q - 8'h01;
        end
        SHIFT: begin
          if (press[3] && !press[4])      pattern_d = {pattern_q[6:0], pattern_q[7]};
          else if (press[4] && !press[3]) pattern_d = {pattern_q[0], pattern_q[7:1]};
        end
        default: state_d = MIRROR;
      endcase
    end
    case (state_d)
      COUNT:   leds_d = count_d;
      SHIFT:   leds_d = pattern_d;
      default: leds_d = sw_db;
    endcase
  end

  assign io.o_leds      = leds_q;
  assign io.o_mode      = state_q;
  assign io.o_btn_db    = btn_db;
  assign io.o_sw_db     = sw_db;
  assign io.o_btn_press = press;

endmodule

// File: tb/tb_basic_io_ctrl.sv
// Scoreboard bench for basic_io_ctrl with TICK_DIV=4, DEBOUNCE_TICKS=3.
module tb_basic_io_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [9:0] lq[$];
  logic [5:0] pq[$];
  logic [9:0] prev_ml = 10'h000;

  localparam logic [5:0] B_C = 6'b000001, B_U = 6'b000010, B_D = 6'b000100,
                         B_L = 6'b001000, B_R = 6'b010000, B_AUX = 6'b100000;

  basic_io_if io();

  basic_io_ctrl #(.TICK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io   (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Expectation: one press pulse and, if given, the resulting {mode,leds} change.
  task automatic press(input logic [5:0] b, input bit led_change, input logic [9:0] ml);
    pq.push_back(b);
    if (led_change) lq.push_back(ml);
    io.i_buttons = b;
    repeat (20) @(negedge clk);
    io.i_buttons = 6'h00;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [9:0] e;
    logic [5:0] p;
    forever begin
      @(negedge clk);
      if (io.o_btn_press != 6'h00) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL press_unexpected got=%b expected=none", io.o_btn_press);
        end else begin
          p = pq.pop_front();
          if (io.o_btn_press !== p) begin
            errors++;
            $display("FAIL press got=%b expected=%b", io.o_btn_press, p);
          end
        end
      end
      if ({io.o_mode, io.o_leds} !== prev_ml) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL leds_unexpected got mode=%0d leds=%h expected=no change",
                   io.o_mode, io.o_leds);
        end else begin
          e = lq.pop_front();
          if ({io.o_mode, io.o_leds} !== e) begin
            errors++;
            $display("FAIL leds got mode=%0d leds=%h expected mode=%0d leds=%h",
                     io.o_mode, io.o_leds, e[9:8], e[7:0]);
          end
        end
        prev_ml = {io.o_mode, io.o_leds};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    io.i_buttons  = 6'h00;
    io.i_switches = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_leds",  io.o_leds, 8'h00);
    chk("rst_mode",  io.o_mode, 2'd0);
    chk("rst_btndb", io.o_btn_db, 6'h00);
    chk("rst_swdb",  io.o_sw_db, 8'h00);
    chk("rst_press", io.o_btn_press, 6'h00);

    // Switches debounce into MIRROR
    lq.push_back({2'd0, 8'hA5});
    rst = 1'b0;
    io.i_switches = 8'hA5;
    n = 0;
    while (n < 30 && io.o_sw_db !== 8'hA5) begin
      @(negedge clk);
      n++;
    end
    chk("swdb_latency_ok", (n <= 18), 1'b1);
    repeat (10) @(negedge clk);

    // Short glitch must be filtered
    seen = 1'b0;
    io.i_buttons = B_U;
    repeat (5) begin
      @(negedge clk);
      if (io.o_btn_db != 6'h00) seen = 1'b1;
    end
    io.i_buttons = 6'h00;
    repeat (25) begin
      @(negedge clk);
      if (io.o_btn_db != 6'h00) seen = 1'b1;
    end
    chk("glitch_filtered", seen, 1'b0);

    press(B_U, 1'b0, 10'h000);

    // COUNT mode
    press(B_C, 1'b1, {2'd1, 8'h00});
    press(B_U, 1'b1, {2'd1, 8'h01});
    press(B_U, 1'b1, {2'd1, 8'h02});
    press(B_U, 1'b1, {2'd1, 8'h03});
    press(B_D, 1'b1, {2'd1, 8'h02});
    press(B_D, 1'b1, {2'd1, 8'h01});
    press(B_D, 1'b1, {2'd1, 8'h00});
    press(B_D, 1'b1, {2'd1, 8'hFF});

    io.i_switches = 8'h7F;
    repeat (20) @(negedge clk);
    press(B_R, 1'b1, {2'd1, 8'h7F});
    press(B_U, 1'b1, {2'd1, 8'h80});
    press(B_U | B_D, 1'b0, 10'h000);
    chk("count_ud_hold", io.o_leds, 8'h80);
    chk("count_mode",    io.o_mode, 2'd1);

    // SHIFT mode with zero switches seeds 01
    io.i_switches = 8'h00;
    repeat (20) @(negedge clk);
    press(B_C, 1'b1, {2'd2, 8'h01});
    press(B_L, 1'b1, {2'd2, 8'h02});
    press(B_R, 1'b1, {2'd2, 8'h01});
    press(B_R, 1'b1, {2'd2, 8'h80});
    press(B_L, 1'b1, {2'd2, 8'h01});
    press(B_L | B_R, 1'b0, 10'h000);

    io.i_switches = 8'h3C;
    repeat (20) @(negedge clk);
    press(B_AUX | B_C, 1'b1, {2'd0, 8'h3C});
    press(B_C, 1'b1, {2'd1, 8'h00});

    // Reset in the middle of a debounce
    io.i_buttons = B_U;
    repeat (8) @(negedge clk);
    lq.push_back({2'd0, 8'h00});
    #2 rst = 1'b1;
    #1;
    chk("midrst_leds",  io.o_leds, 8'h00);
    chk("midrst_mode",  io.o_mode, 2'd0);
    chk("midrst_btndb", io.o_btn_db, 6'h00);
    chk("midrst_swdb",  io.o_sw_db, 8'h00);
    chk("midrst_press", io.o_btn_press, 6'h00);
    repeat (2) @(negedge clk);
    pq.push_back(B_U);
    lq.push_back({2'd0, 8'h3C});
    rst = 1'b0;
    n = 0;
    while (n < 30 && io.o_btn_db[1] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("redebounce_cycles", n, 12);
    repeat (5) @(negedge clk);
    io.i_buttons = 6'h00;
    repeat (25) @(negedge clk);

    chk("led_queue_empty",   lq.size(), 0);
    chk("press_queue_empty", pq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
